strtol: RTL and testbench
=========================

# strtol

Parametrised string-to-integer engine for the eForth outer interpreter. It is the successor of the single-base digit accumulator. It acts as a bus master that walks a NUL/space/any-non-digit terminated string in byte memory starting at `tib`, with:
- leading-space skip and optional `+`/`-` sign;
- any radix 2..36, one digit per clock;
- signed-overflow saturation;
- reporting of the first unconsumed address so the parser can resume.

## Interface
- ASZ, 17, byte address width
- DSZ, 32, result width (two's complement)
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin conversion; sampled only when bsy=0
- base  in  6  radix, legal 2..36, latched on start
- tib  in  ASZ  address of first character, latched on start
- ai  out  ASZ  memory read address; memory returns ch one cycle later (synchronous read)
- ch  in  8  byte read from address presented on previous cycle
- bsy  out  1  conversion in progress
- done  out  1  one-cycle pulse, result outputs valid from this cycle until next start
- err  out  1  no digit converted, or illegal base
- ovf  out  1  magnitude exceeded signed range; vo saturated
- vo  out  DSZ  signed result
- nxt  out  ASZ  address of terminating (first unconsumed) character

## Operation
- States are IDLE, PRE, LEAD, ACC, FIN.
- Digit decode:
  - '0'-'9' map to 0-9; 'a'-'z' and 'A'-'Z' map to 10-35; all other bytes are invalid.
  - A digit is valid iff decoded value < latched base.
- IDLE:
  - When start=1: latch base/tib, set ai<=tib, clear acc/neg/ovf/cnt, set bsy<=1, go PRE.
  - If base<2 or base>36: go FIN directly, which yields err=1 and vo=0.
- PRE: ai<=ai+1, go LEAD (first byte arrives next cycle).
- LEAD (ch = byte at ai-1):
  - ' ': ai++, stay in LEAD.
  - '-': neg<=1, ai++, go ACC.
  - '+': ai++, go ACC.
  - valid digit: accumulate, ai++, go ACC.
  - otherwise: go FIN.
- ACC:
  - valid digit: accumulate, cnt++, ai++, stay in ACC.
  - anything else: go FIN.
  - There is no length limit.
- Accumulate:
  - Compute t = acc*base + n in DSZ+6 bits.
  - lim = neg ? 2^(DSZ-1) : 2^(DSZ-1)-1.
  - If t>lim: acc<=lim and ovf<=1 (sticky). Otherwise acc<=t.
  - Digits after overflow are still consumed.
- FIN:
  - vo<=neg ? -acc : acc (acc of 2^(DSZ-1) negates to the minimum value).
  - nxt<=ai-1; err<=(cnt==0); done<=1; bsy<=0; go IDLE.
  - A lone sign or leading spaces followed by a non-digit gives err=1, vo=0, nxt pointing at the non-digit.
- start while bsy=1 is ignored.

## Timing
- Reset values: state IDLE, ai=0, bsy=0, done=0, err=0, ovf=0, vo=0, nxt=0, and internal acc/neg/cnt=0.
- rst mid-conversion aborts immediately to reset values; no done pulse is produced.
- Cycle count, with start sampled at edge 0, N spaces, s sign chars (0/1), D digits:
  - done is registered at edge N+s+D+3 and is high for exactly one cycle.
  - bsy is high from edge 0 through edge N+s+D+2.
- A back-to-back start in the cycle done is high is accepted, because bsy=0 in that cycle.
- Outputs vo/err/ovf/nxt hold until the next accepted start, which clears err/ovf only.
- ai advances exactly once per consumed character and never past the terminator's address+1.

## Test plan
- "123\0" at tib=0x100, base 10 -> done at edge 6, vo=123, err=0, ovf=0, nxt=0x103.
- "  -7fffffff " at tib=0, base 16, DSZ=32 -> vo=0x80000001, nxt=0x0B, done at edge 14.
- "2147483648\0" base 10 -> vo=0x7FFFFFFF, ovf=1; "-2147483648\0" -> vo=0x80000000, ovf=0; "-99999999999" -> vo=0x80000000, ovf=1, nxt after the last digit.
- Base 2 on "1012": the '2' is invalid, so vo=5, nxt at '2'. Base 36 on "zZ " -> vo=1295.
- "-x" base 10 -> err=1, vo=0, nxt=tib+1. Base 1 -> err=1 at edge 2 with no memory reads beyond tib.
- Assert rst during ACC of "12345" -> all outputs 0 at once, no done. Then start on "42" -> vo=42. Also check that start while bsy=1 is ignored.

Source files
------------

// File: rtl/strtol_if.sv
// rtl/strtol_if.sv - request, memory-read and result signals of the strtol engine
// master is the conversion engine; slave is the client/memory side.
interface strtol_if #(
  parameter int ASZ = 17,
  parameter int DSZ = 32
);
  logic           start;
  logic [5:0]     base;
  logic [ASZ-1:0] tib;
  logic [ASZ-1:0] ai;
  logic [7:0]     ch;
  logic           bsy;
  logic           done;
  logic           err;
  logic           ovf;
  logic [DSZ-1:0] vo;
  logic [ASZ-1:0] nxt;

  modport master (
    input  start, base, tib, ch,
    output ai, bsy, done, err, ovf, vo, nxt
  );

  modport slave (
    output start, base, tib, ch,
    input  ai, bsy, done, err, ovf, vo, nxt
  );
endinterface

// File: rtl/strtol.sv
// rtl/strtol.sv - string-to-integer engine walking byte memory, radix 2..36 with saturation
// One character per clock; memory read is synchronous, so ch always holds the byte at ai-1.
module strtol #(
  parameter int ASZ = 17,
  parameter int DSZ = 32
) (
  input  logic      clk,
  input  logic      rst,
  strtol_if.master  bus
);
  localparam int TW = DSZ + 6;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_LEAD = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [ASZ-1:0] ai_q, ai_d;
  logic [ASZ-1:0] nxt_q, nxt_d;
  logic [ASZ-1:0] cnt_q, cnt_d;
  logic [5:0]     base_q, base_d;
  logic [DSZ-1:0] acc_q, acc_d;
  logic [DSZ-1:0] vo_q, vo_d;
  logic           neg_q, neg_d;
  logic           ovf_q, ovf_d;
  logic           bsy_q, bsy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [5:0]     dig;
  logic           dig_ok;
  logic [TW-1:0]  t;
  logic [TW-1:0]  lim;
  logic [DSZ-1:0] acc_nx;
  logic           ovf_nx;

  // Non-digits decode to 63, which is never below a legal base.
  always_comb begin
    dig = 6'h3f;
    if (bus.ch >= 8'h30 && bus.ch <= 8'h39)      dig = 6'(bus.ch - 8'h30);
    else if (bus.ch >= 8'h61 && bus.ch <= 8'h7a) dig = 6'(bus.ch - 8'h57);
    else if (bus.ch >= 8'h41 && bus.ch <= 8'h5a) dig = 6'(bus.ch - 8'h37);
    dig_ok = dig < base_q;
  end

  // Negative results may reach 2^(DSZ-1), which negates to the minimum value.
  always_comb begin
    t   = TW'(acc_q) * TW'(base_q) + TW'(dig);
    lim = (TW'(1) << (DSZ - 1)) - TW'(!neg_q);
    if (t > lim) begin
      acc_nx = lim[DSZ-1:0];
      ovf_nx = 1'b1;
    end else begin
      acc_nx = t[DSZ-1:0];
      ovf_nx = ovf_q;
    end
  end

  always_comb begin
    state_d = state_q;
    ai_d    = ai_q;
    nxt_d   = nxt_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    acc_d   = acc_q;
    vo_d    = vo_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    bsy_d   = bsy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          base_d  = bus.base;
          ai_d    = bus.tib;
          acc_d   = '0;
          neg_d   = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b0;
          bsy_d   = 1'b1;
          state_d = (bus.base >= 6'd2 && bus.base <= 6'd36) ? S_PRE : S_FIN;
        end
      end
      S_PRE: begin
        ai_d    = ai_q + ASZ'(1);
        state_d = S_LEAD;
      end
      S_LEAD: begin
        if (bus.ch == 8'h20) begin
          ai_d = ai_q + ASZ'(1);
        end else if (bus.ch == 8'h2d) begin
          neg_d   = 1'b1;
          ai_d    = ai_q + ASZ'(1);
          state_d = S_ACC;
        end else if (bus.ch == 8'h2b) begin
          ai_d    = ai_q + ASZ'(1);
          state_d = S_ACC;
        end else if (dig_ok) begin
          acc_d   = acc_nx;
          ovf_d   = ovf_nx;
          cnt_d   = cnt_q + ASZ'(1);
          ai_d    = ai_q + ASZ'(1);
          state_d = S_ACC;
        end else begin
          state_d = S_FIN;
        end
      end
      S_ACC: begin
        if (dig_ok) begin
          acc_d = acc_nx;
          ovf_d = ovf_nx;
          cnt_d = cnt_q + ASZ'(1);
          ai_d  = ai_q + ASZ'(1);
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        vo_d    = neg_q ? -acc_q : acc_q;
        nxt_d   = ai_q - ASZ'(1);
        err_d   = (cnt_q == '0);
        done_d  = 1'b1;
        bsy_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ai_q    <= '0;
      nxt_q   <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      vo_q    <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      bsy_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ai_q    <= ai_d;
      nxt_q   <= nxt_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      vo_q    <= vo_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      bsy_q   <= bsy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.ai   = ai_q;
  assign bus.bsy  = bsy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.ovf  = ovf_q;
  assign bus.vo   = vo_q;
  assign bus.nxt  = nxt_q;
endmodule

// File: tb/tb_strtol.sv
// tb/tb_strtol.sv - directed bench for strtol with an expected-result queue
// Each run pushes its expectation before start and pops it when done rises.
module tb_strtol;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  strtol_if #(.ASZ(17), .DSZ(32)) bus ();

  strtol #(.ASZ(17), .DSZ(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:131071];
  always @(posedge clk) bus.ch <= mem[bus.ai];

  typedef struct {
    logic [31:0] vo;
    logic        err;
    logic        ovf;
    logic [16:0] nxt;
    int          lat;
    bit          chk_nxt;
  } exp_t;

  exp_t sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int addr, input string s);
    for (int i = 0; i < s.len(); i++) mem[addr + i] = s[i];
    mem[addr + s.len()] = 8'h00;
  endtask

  task automatic expect_res(input logic [31:0] vo, input logic err, input logic ovf,
                            input logic [16:0] nxt, input int lat, input bit chk_nxt);
    exp_t e;
    e.vo = vo; e.err = err; e.ovf = ovf; e.nxt = nxt; e.lat = lat; e.chk_nxt = chk_nxt;
    sb.push_back(e);
  endtask

  task automatic start_conv(input logic [16:0] a, input logic [5:0] b);
    bus.tib   = a;
    bus.base  = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("bsy_edge0", bus.bsy, 1);
    check("done_low_edge0", bus.done, 0);
  endtask

  task automatic wait_done();
    int   k;
    exp_t e;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (k == 2) bus.start = 1'b0;
    end while (!bus.done && k < 200);
    check("done_seen", bus.done, 1);
    e = sb.pop_front();
    check("vo", bus.vo, e.vo);
    check("err", bus.err, e.err);
    check("ovf", bus.ovf, e.ovf);
    check("bsy_at_done", bus.bsy, 0);
    if (e.chk_nxt) check("nxt", bus.nxt, e.nxt);
    if (e.lat >= 0) check("done_edge", k, e.lat);
    else check("done_by_edge2", k <= 2, 1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.base  = 6'd10;
    bus.tib   = '0;
    load(17'h100, "123");
    load(17'h000, "  -7fffffff ");
    load(17'h300, "2147483648");
    load(17'h400, "-2147483648");
    load(17'h500, "-99999999999");
    load(17'h600, "1012");
    load(17'h700, "zZ ");
    load(17'h800, "-x");
    load(17'h900, "123");
    load(17'hA00, "12345");
    load(17'hB00, "42");

    repeat (2) @(posedge clk);
    #1;
    check("rst_bsy", bus.bsy, 0);
    check("rst_done", bus.done, 0);
    check("rst_vo", bus.vo, 0);
    check("rst_nxt", bus.nxt, 0);
    check("rst_ai", bus.ai, 0);
    rst = 1'b0;

    expect_res(32'd123, 0, 0, 17'h103, 6, 1);
    start_conv(17'h100, 6'd10);
    wait_done();

    expect_res(32'h80000001, 0, 0, 17'h00B, 14, 1);
    start_conv(17'h000, 6'd16);
    wait_done();

    expect_res(32'h7FFFFFFF, 0, 1, 17'h30A, 13, 1);
    start_conv(17'h300, 6'd10);
    wait_done();

    expect_res(32'h80000000, 0, 0, 17'h40B, 14, 1);
    start_conv(17'h400, 6'd10);
    wait_done();

    expect_res(32'h80000000, 0, 1, 17'h50C, 15, 1);
    start_conv(17'h500, 6'd10);
    wait_done();

    expect_res(32'd5, 0, 0, 17'h603, 6, 1);
    start_conv(17'h600, 6'd2);
    wait_done();

    expect_res(32'd1295, 0, 0, 17'h702, 5, 1);
    start_conv(17'h700, 6'd36);
    wait_done();

    // abort "12345" while accumulating; outputs drop at once, no done follows
    start_conv(17'hA00, 6'd10);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_bsy", bus.bsy, 0);
    check("abort_vo", bus.vo, 0);
    check("abort_nxt", bus.nxt, 0);
    check("abort_ai", bus.ai, 0);
    check("abort_err", bus.err, 0);
    check("abort_ovf", bus.ovf, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("abort_no_done", bus.done, 0);
    end
    rst = 1'b0;

    expect_res(32'd0, 1, 0, 17'h801, 4, 1);
    start_conv(17'h800, 6'd10);
    wait_done();

    expect_res(32'd0, 1, 0, 17'h000, -1, 0);
    start_conv(17'h900, 6'd1);
    check("base1_ai_edge0", bus.ai, 17'h900);
    wait_done();
    check("base1_ai_done", bus.ai, 17'h900);

    // second start while busy must be ignored
    expect_res(32'd42, 0, 0, 17'hB02, 5, 1);
    start_conv(17'hB00, 6'd10);
    bus.base  = 6'd3;
    bus.tib   = 17'h100;
    bus.start = 1'b1;
    wait_done();

    @(posedge clk);
    #1;
    check("done_one_cycle", bus.done, 0);
    check("vo_hold", bus.vo, 42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
